// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite bus widths, transfer encodings and the responder state type.
// Optional feature macro: AHB_SLV_ERR_EN (adds the two-cycle ERROR states).
package ahb_pkg;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned SIZE_WIDTH  = 3;
  localparam int unsigned BURST_WIDTH = 3;
  localparam int unsigned PROT_WIDTH  = 4;
  localparam int unsigned TRANS_WIDTH = 2;

  typedef enum logic [1:0] {
    TransIdle   = 2'd0,
    TransBusy   = 2'd1,
    TransNonseq = 2'd2,
    TransSeq    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SizeByte  = 3'd0,
    SizeHalf  = 3'd1,
    SizeWord  = 3'd2,
    SizeDword = 3'd3,
    Size16B   = 3'd4,
    Size32B   = 3'd5,
    Size64B   = 3'd6,
    Size128B  = 3'd7
  } hsize_e;

  typedef enum logic {
    RespOkay  = 1'b0,
    RespError = 1'b1
  } hresp_e;

`ifdef AHB_SLV_ERR_EN
  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} ahb_slv_state_e;
`else
  typedef enum logic [1:0] {StIdle, StWait, StData} ahb_slv_state_e;
`endif

  // Byte-lane mask for a transfer of 2^size bytes starting at lane 0 (size <= 3).
  function automatic logic [7:0] lane_mask(input logic [1:0] size);
    lane_mask = 8'((9'd1 << (4'd1 << size)) - 9'd1);
  endfunction

endpackage

// File: rtl/ahb_slv_byte_mem.sv
// ahb_slv_byte_mem: DATA_WIDTH x MEM_DEPTH storage with per-byte write enables
// and an asynchronous word read. Contents are deliberately not reset.
module ahb_slv_byte_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  localparam int unsigned Lanes     = DATA_WIDTH / 8,
  localparam int unsigned IdxW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  hclock,
  input  logic                  we,
  input  logic [Lanes-1:0]      be,
  input  logic [IdxW-1:0]       idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Store only the enabled byte lanes of the write word.
  always_ff @(posedge hclock) begin
    if (we) begin
      for (int b = 0; b < Lanes; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// ahb_lite_mem_slave: AHB-Lite memory responder with programmable wait states.
// Optional feature macro: AHB_SLV_ERR_EN enables illegal-access detection and the
// two-cycle ERROR response; without it addresses wrap/align and hresp stays OKAY.
module ahb_lite_mem_slave #(
  parameter int unsigned ADDR_WIDTH  = ahb_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = ahb_pkg::DATA_WIDTH,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                            hclock,
  input  logic                            hresetn,
  input  logic                            hsel,
  input  logic [ADDR_WIDTH-1:0]           haddr,
  input  logic                            hwrite,
  input  logic [ahb_pkg::SIZE_WIDTH-1:0]  hsize,
  input  logic [ahb_pkg::BURST_WIDTH-1:0] hburst,
  input  logic [ahb_pkg::PROT_WIDTH-1:0]  hprot,
  input  logic [ahb_pkg::TRANS_WIDTH-1:0] htrans,
  input  logic                            hready,
  input  logic [DATA_WIDTH-1:0]           hwdata,
  output logic [DATA_WIDTH-1:0]           hrdata,
  output logic                            hreadyout,
  output logic                            hresp
);
  import ahb_pkg::*;

  localparam int unsigned Lanes    = DATA_WIDTH / 8;
  localparam int unsigned LaneBits = $clog2(Lanes);
  localparam int unsigned IdxW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CntW     = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  ahb_slv_state_e        state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [SIZE_WIDTH-1:0] size_q;

  logic                  valid_phase, accept;
  logic [1:0]            esize;
  logic [LaneBits-1:0]   lane_off;
  logic [Lanes-1:0]      be;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [IdxW-1:0]       idx;
  logic                  we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  unused_inputs;

  assign unused_inputs = ^{hburst, hprot, htrans[0]};

  // hreadyout is low exactly in WAIT/ERR1, the states that must not take a new phase.
  assign valid_phase = hsel && hready && htrans[1];
  assign accept      = valid_phase && hreadyout;

`ifdef AHB_SLV_ERR_EN
  logic [ADDR_WIDTH-1:0] word_req;
  logic [LaneBits-1:0]   align_req;
  logic                  illegal;

  // Classify the incoming address phase: out of range, misaligned or oversize.
  always_comb begin
    word_req  = haddr >> LaneBits;
    align_req = LaneBits'((8'd1 << hsize) - 8'd1);
    illegal   = (word_req >= ADDR_WIDTH'(MEM_DEPTH)) ||
                ((haddr[LaneBits-1:0] & align_req) != '0) ||
                (hsize > SIZE_WIDTH'(LaneBits));
  end
`endif

  // Next-state logic: IDLE/DATA/ERR2 all dispatch a newly accepted phase the same way.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StData;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef AHB_SLV_ERR_EN
      StErr1: state_d = StErr2;
`endif
      default: begin
        state_d = StIdle;
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = CntLoad;
          end else begin
            state_d = StData;
          end
`ifdef AHB_SLV_ERR_EN
          if (illegal) begin
            state_d = StErr1;
            cnt_d   = cnt_q;
          end
`endif
        end
      end
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge hclock or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture address-phase controls for the following data phase.
  always_ff @(posedge hclock or negedge hresetn) begin
    if (!hresetn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else if (accept) begin
      addr_q  <= haddr;
      write_q <= hwrite;
      size_q  <= hsize;
    end
  end

  // Data-phase decode: clamp size, align lane offset down, wrap word index.
  always_comb begin
    esize    = (size_q > SIZE_WIDTH'(LaneBits)) ? 2'(LaneBits) : size_q[1:0];
    lane_off = addr_q[LaneBits-1:0] & ~LaneBits'((4'd1 << esize) - 4'd1);
    be       = Lanes'(lane_mask(esize)) << lane_off;
    word_q   = addr_q >> LaneBits;
    idx      = IdxW'(word_q % ADDR_WIDTH'(MEM_DEPTH));
    we       = (state_q == StData) && write_q;
  end

  ahb_slv_byte_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .hclock(hclock),
    .we    (we),
    .be    (be),
    .idx   (idx),
    .wdata (hwdata),
    .rdata (mem_rdata)
  );

  // Bus outputs decoded from state; read data only appears in a read DATA cycle.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = RespOkay;
    hrdata    = '0;
    case (state_q)
      StWait: hreadyout = 1'b0;
      StData: if (!write_q) hrdata = mem_rdata;
`ifdef AHB_SLV_ERR_EN
      StErr1: begin
        hreadyout = 1'b0;
        hresp     = RespError;
      end
      StErr2: hresp = RespError;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Directed bench for ahb_lite_mem_slave: three instances with WAIT_STATES 0, 2, 3
// (index 0, 1, 2), each acting as the only slave so its hready is its own hreadyout.
module tb_ahb_lite_mem_slave;
  import ahb_pkg::*;

`ifdef AHB_SLV_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic                   hclock;
  logic                   hresetn;
  logic [2:0]             sel;
  logic [ADDR_WIDTH-1:0]  haddr;
  logic                   hwrite;
  logic [SIZE_WIDTH-1:0]  hsize;
  logic [BURST_WIDTH-1:0] hburst;
  logic [PROT_WIDTH-1:0]  hprot;
  logic [TRANS_WIDTH-1:0] htrans;
  logic [DATA_WIDTH-1:0]  hwdata;
  logic [2:0]             hreadyout_v;
  logic [2:0]             hresp_v;
  logic [DATA_WIDTH-1:0]  hrdata_v [3];

  int   cur;
  logic cur_ready, cur_resp;
  logic [31:0] cur_rdata;
  int   tests;
  int   failures;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_lite_mem_slave #(
      .WAIT_STATES((g == 0) ? 0 : g + 1)
    ) u_dut (
      .hclock   (hclock),
      .hresetn  (hresetn),
      .hsel     (sel[g]),
      .haddr    (haddr),
      .hwrite   (hwrite),
      .hsize    (hsize),
      .hburst   (hburst),
      .hprot    (hprot),
      .htrans   (htrans),
      .hready   (hreadyout_v[g]),
      .hwdata   (hwdata),
      .hrdata   (hrdata_v[g]),
      .hreadyout(hreadyout_v[g]),
      .hresp    (hresp_v[g])
    );
  end

  always_comb begin
    cur_ready = hreadyout_v[cur];
    cur_resp  = hresp_v[cur];
    cur_rdata = hrdata_v[cur];
  end

  initial hclock = 1'b0;
  always #5 hclock = ~hclock;

  // One single transfer on instance k; entered and left just after a rising edge.
  task automatic do_xfer(input int k, input logic [31:0] addr, input logic wr,
                         input logic [2:0] size, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int low, output logic resp,
                         output logic resp_low);
    bit done;
    cur = k; sel = 3'b001 << k; haddr = addr; hwrite = wr; hsize = size; htrans = 2'b10;
    @(posedge hclock); #1;
    sel = '0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hwdata = wdata;
    low = 0; resp_low = 1'b0; resp = 1'b0; rdata = '0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge hclock);
      if (cur_ready === 1'b1) begin
        rdata = cur_rdata; resp = cur_resp; done = 1'b1;
      end else begin
        low++; resp_low = resp_low | cur_resp;
      end
      @(posedge hclock); #1;
    end
    tests++;
    if (!done) begin
      failures++;
      $display("FAIL xfer_timeout k=%0d addr=%h: hreadyout low for %0d cycles, required high", k,
               addr, low);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cur = k; #1;
      tests += 3;
      if (cur_ready !== 1'b1) begin
        failures++; $display("FAIL reset_hreadyout k=%0d: got %b, required 1", k, cur_ready);
      end
      if (cur_resp !== 1'b0) begin
        failures++; $display("FAIL reset_hresp k=%0d: got %b, required 0", k, cur_resp);
      end
      if (cur_rdata !== 32'h0) begin
        failures++; $display("FAIL reset_hrdata k=%0d: got %h, required 0", k, cur_rdata);
      end
    end
  endtask

  task automatic test_idle_busy();
    for (int t = 0; t < 2; t++) begin
      cur = 0; sel = 3'b001; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2; htrans = 2'(t);
      @(posedge hclock); #1;
      sel = '0; htrans = 2'b00;
      @(negedge hclock);
      tests += 3;
      if (cur_ready !== 1'b1) begin
        failures++; $display("FAIL idle_hreadyout trans=%0d: got %b, required 1", t, cur_ready);
      end
      if (cur_resp !== 1'b0) begin
        failures++; $display("FAIL idle_hresp trans=%0d: got %b, required 0", t, cur_resp);
      end
      if (cur_rdata !== 32'h0) begin
        failures++; $display("FAIL idle_hrdata trans=%0d: got %h, required 0", t, cur_rdata);
      end
      @(posedge hclock); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; int low; logic rsp, rspl;
    do_xfer(2, 32'h10, 1'b1, 3'd2, 32'h0BAD_F00D, rd, low, rsp, rspl);
    tests++;
    if (low !== 3) begin
      failures++; $display("FAIL ws3_write_wait: got %0d low cycles, required 3", low);
    end
    cur = 2; sel = 3'b100; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
    @(posedge hclock); #1;
    sel = '0; htrans = 2'b00; hwdata = 32'hDEAD_BEEF;
    @(posedge hclock); #2;
    hresetn = 1'b0;
    #1;
    tests += 3;
    if (cur_ready !== 1'b1) begin
      failures++; $display("FAIL midreset_hreadyout: got %b, required 1", cur_ready);
    end
    if (cur_resp !== 1'b0) begin
      failures++; $display("FAIL midreset_hresp: got %b, required 0", cur_resp);
    end
    if (cur_rdata !== 32'h0) begin
      failures++; $display("FAIL midreset_hrdata: got %h, required 0", cur_rdata);
    end
    @(negedge hclock);
    hresetn = 1'b1;
    @(posedge hclock); #1;
    do_xfer(2, 32'h10, 1'b0, 3'd2, 32'h0, rd, low, rsp, rspl);
    tests += 2;
    if (rd !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL midreset_readback: got %h, required 0bad_f00d", rd);
    end
    if (low !== 3) begin
      failures++; $display("FAIL ws3_read_wait: got %0d low cycles, required 3", low);
    end
  endtask

  task automatic test_back_to_back();
    cur = 0; sel = 3'b001; haddr = 32'h4; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
    @(posedge hclock); #1;
    haddr = 32'h4; hwrite = 1'b0; htrans = 2'b10; hwdata = 32'hA5A5_1234;
    @(negedge hclock);
    tests++;
    if (cur_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_write_ready: got %b, required 1", cur_ready);
    end
    @(posedge hclock); #1;
    sel = '0; htrans = 2'b00; hwdata = 32'h0;
    @(negedge hclock);
    tests += 3;
    if (cur_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_read_ready: got %b, required 1", cur_ready);
    end
    if (cur_rdata !== 32'hA5A5_1234) begin
      failures++; $display("FAIL b2b_read_data: got %h, required a5a5_1234", cur_rdata);
    end
    if (cur_resp !== 1'b0) begin
      failures++; $display("FAIL b2b_read_resp: got %b, required 0", cur_resp);
    end
    @(posedge hclock); #1;
    @(negedge hclock);
    tests++;
    if (cur_rdata !== 32'h0) begin
      failures++; $display("FAIL b2b_after_hrdata: got %h, required 0", cur_rdata);
    end
    @(posedge hclock); #1;
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; int low; logic rsp, rspl;
    do_xfer(1, 32'h20, 1'b1, 3'd2, 32'h1357_9BDF, rd, low, rsp, rspl);
    tests++;
    if (low !== 2) begin
      failures++; $display("FAIL ws2_write_wait: got %0d low cycles, required 2", low);
    end
    do_xfer(1, 32'h20, 1'b0, 3'd2, 32'h0, rd, low, rsp, rspl);
    tests += 3;
    if (low !== 2) begin
      failures++; $display("FAIL ws2_read_wait: got %0d low cycles, required 2", low);
    end
    if (rd !== 32'h1357_9BDF) begin
      failures++; $display("FAIL ws2_read_data: got %h, required 1357_9bdf", rd);
    end
    if (rsp !== 1'b0) begin
      failures++; $display("FAIL ws2_read_resp: got %b, required 0", rsp);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int low; logic rsp, rspl;
    do_xfer(0, 32'h100, 1'b1, 3'd2, 32'h1111_1111, rd, low, rsp, rspl);
    do_xfer(0, 32'h103, 1'b1, 3'd0, 32'h7700_0000, rd, low, rsp, rspl);
    do_xfer(0, 32'h100, 1'b0, 3'd2, 32'h0, rd, low, rsp, rspl);
    tests++;
    if (rd !== 32'h7711_1111) begin
      failures++; $display("FAIL byte_lane3: got %h, required 7711_1111", rd);
    end
    do_xfer(0, 32'h101, 1'b1, 3'd0, 32'hEEEE_55EE, rd, low, rsp, rspl);
    do_xfer(0, 32'h100, 1'b0, 3'd2, 32'h0, rd, low, rsp, rspl);
    tests++;
    if (rd !== 32'h7711_5511) begin
      failures++; $display("FAIL byte_lane1: got %h, required 7711_5511", rd);
    end
    do_xfer(0, 32'h104, 1'b1, 3'd2, 32'h1111_1111, rd, low, rsp, rspl);
    do_xfer(0, 32'h106, 1'b1, 3'd1, 32'h2222_0000, rd, low, rsp, rspl);
    do_xfer(0, 32'h104, 1'b0, 3'd2, 32'h0, rd, low, rsp, rspl);
    tests++;
    if (rd !== 32'h2222_1111) begin
      failures++; $display("FAIL half_upper: got %h, required 2222_1111", rd);
    end
  endtask

  // Illegal-looking beats: ERROR with the macro, wrap/align/clamp without it.
  task automatic test_illegal();
    logic [31:0] rd; int low; logic rsp, rspl;
    logic [31:0] addrs [3];
    logic [2:0]  sizes [3];
    logic [31:0] wdat  [3];
    logic [31:0] alt   [3];
    addrs = '{32'h1000, 32'h1, 32'h0};
    sizes = '{3'd2, 3'd1, 3'd3};
    wdat  = '{32'hCAFE_BABE, 32'h0000_BEEF, 32'h55AA_55AA};
    alt   = '{32'hCAFE_BABE, 32'h0102_BEEF, 32'h55AA_55AA};
    for (int i = 0; i < 3; i++) begin
      do_xfer(0, 32'h0, 1'b1, 3'd2, 32'h0102_0304, rd, low, rsp, rspl);
      do_xfer(0, addrs[i], 1'b1, sizes[i], wdat[i], rd, low, rsp, rspl);
      tests += 3;
      if (low !== (ErrEn ? 1 : 0)) begin
        failures++;
        $display("FAIL illegal%0d_wait: got %0d low cycles, required %0d", i, low, ErrEn ? 1 : 0);
      end
      if (rspl !== ErrEn) begin
        failures++; $display("FAIL illegal%0d_err1_resp: got %b, required %b", i, rspl, ErrEn);
      end
      if (rsp !== ErrEn) begin
        failures++; $display("FAIL illegal%0d_err2_resp: got %b, required %b", i, rsp, ErrEn);
      end
      do_xfer(0, 32'h0, 1'b0, 3'd2, 32'h0, rd, low, rsp, rspl);
      tests += 2;
      if (rd !== (ErrEn ? 32'h0102_0304 : alt[i])) begin
        failures++;
        $display("FAIL illegal%0d_mem: got %h, required %h", i, rd,
                 ErrEn ? 32'h0102_0304 : alt[i]);
      end
      if (rsp !== 1'b0 || low !== 0) begin
        failures++;
        $display("FAIL illegal%0d_next_read: got resp=%b low=%0d, required resp=0 low=0", i,
                 rsp, low);
      end
    end
  endtask

  initial begin
    tests = 0; failures = 0; cur = 0;
    hresetn = 1'b0; sel = '0; haddr = '0; hwrite = 1'b0; hsize = '0;
    hburst = '0; hprot = '0; htrans = '0; hwdata = '0;
    repeat (2) @(posedge hclock);
    @(negedge hclock);
    test_reset();
    hresetn = 1'b1;
    @(posedge hclock); #1;
    test_idle_busy();
    test_reset_mid_wait();
    test_back_to_back();
    test_wait_states();
    test_byte_lanes();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
